// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the three-digit multiplexed BCD display.
package bcd_disp_pkg;

  // Number of multiplexed digits (hundreds, tens, units).
  localparam int NUM_DIGITS = 3;

  // Scan order: units -> tens -> hundreds -> units.
  typedef enum logic [1:0] {
    S_UNITS = 2'd0,
    S_TENS  = 2'd1,
    S_HUNDS = 2'd2
  } scan_state_e;

  // One BCD value as delivered by the converter.
  typedef struct packed {
    logic [3:0] hunds;
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_digits_t;

  // Seven-segment codes, bit order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // One-hot digit enables, bit order {hunds,tens,units}.
  localparam logic [NUM_DIGITS-1:0] AN_UNITS = 3'b001;
  localparam logic [NUM_DIGITS-1:0] AN_TENS  = 3'b010;
  localparam logic [NUM_DIGITS-1:0] AN_HUNDS = 3'b100;

  // Digit enable belonging to a scan state.
  function automatic logic [NUM_DIGITS-1:0] an_for_state(input scan_state_e s);
    case (s)
      S_UNITS: return AN_UNITS;
      S_TENS:  return AN_TENS;
      S_HUNDS: return AN_HUNDS;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder with a blanking override.
// Non-BCD codes (10..15) render as a centre dash so bad data is visible.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Map the digit to its segment pattern, or dark when blanked.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Three-digit multiplexed seven-segment driver.
// A scan FSM dwells DIV cycles on each digit. New BCD values are parked in a
// pending register and only copied to the displayed (shadow) digits at a frame
// boundary, so a frame never shows a mix of old and new digits.
module bcd_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [3:0]            hunds,
  input  logic [3:0]            tens,
  input  logic [3:0]            units,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);

  localparam int              CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  // Scan state and dwell counter.
  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Pending (most recent load) and shadow (displayed) digits.
  bcd_digits_t pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  bcd_digits_t shadow_q, shadow_d;
  logic        valid_q, valid_d;

  // Registered outputs.
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q;

  // Digit currently being driven.
  logic [3:0]  cur_digit;
  logic        cur_blank;
  logic        dwell_end;
  logic        boundary;
  bcd_digits_t incoming;

  assign incoming  = '{hunds: hunds, tens: tens, units: units};
  assign dwell_end = (cnt_q == CNT_LAST);
  // Last cycle of the hundreds dwell: the scan is about to wrap to units.
  assign boundary  = (state_q == S_HUNDS) && dwell_end;

  // Scan state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_UNITS;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next scan state: count the dwell, advance and wrap on its last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    if (dwell_end) begin
      cnt_d = '0;
      case (state_q)
        S_UNITS: state_d = S_TENS;
        S_TENS:  state_d = S_HUNDS;
        S_HUNDS: state_d = S_UNITS;
        default: state_d = S_UNITS;
      endcase
    end
  end

  // Digit buffering: loads park in pending; the boundary publishes to shadow.
  // A load landing on the boundary itself goes straight to shadow, which also
  // supersedes anything still pending.
  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    shadow_d     = shadow_q;
    valid_d      = valid_q;
    if (boundary) begin
      if (load) begin
        shadow_d     = incoming;
        valid_d      = 1'b1;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        shadow_d     = pend_q;
        valid_d      = 1'b1;
        pend_valid_d = 1'b0;
      end
    end else if (load) begin
      pend_d       = incoming;
      pend_valid_d = 1'b1;
    end
  end

  // Digit buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the digit buffers are reset on purpose: a reset must discard both
    // the displayed and the pending value, not just stop the scan.
    if (rst) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      shadow_q     <= '0;
      valid_q      <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      shadow_q     <= shadow_d;
      valid_q      <= valid_d;
    end
  end

  // Pick the shadow digit for the current state and apply leading-zero
  // blanking; any non-BCD code counts as nonzero so it still shows a dash.
  always_comb begin
    cur_digit = shadow_q.units;
    cur_blank = 1'b1;
    case (state_q)
      S_UNITS: begin
        cur_digit = shadow_q.units;
        cur_blank = !valid_q;
      end
      S_TENS: begin
        cur_digit = shadow_q.tens;
        cur_blank = !valid_q ||
                    ((shadow_q.hunds == 4'd0) && (shadow_q.tens == 4'd0));
      end
      S_HUNDS: begin
        cur_digit = shadow_q.hunds;
        cur_blank = !valid_q || (shadow_q.hunds == 4'd0);
      end
      default: begin
        cur_digit = shadow_q.units;
        cur_blank = 1'b1;
      end
    endcase
  end

  seg7_decode u_decode (
    .digit_i (cur_digit),
    .blank_i (cur_blank),
    .seg_o   (seg_d)
  );

  assign an_d = an_for_state(state_q);

  // Output registers: an/seg follow the state one cycle later; frame_done
  // pulses in the cycle after the boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q        <= SEG_BLANK;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= boundary;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan with DIV=4.
// The stimulus process pushes the expected segment pattern of each upcoming
// frame into a scoreboard queue; the monitor pops one entry whenever a new
// frame starts (an turns to 001) and checks every cycle of that frame.
module tb_bcd_seg_scan;

  localparam int DIV     = 4;
  localparam int FRAME_N = 3 * DIV;

  typedef struct {
    logic [6:0] u;
    logic [6:0] t;
    logic [6:0] h;
  } frame_exp_t;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] hunds;
  logic [3:0] tens;
  logic [3:0] units;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_done;

  int         n_checks;
  int         n_fail;
  bit         mon_stop;
  frame_exp_t sb_q[$];

  bcd_seg_scan #(.DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .hunds      (hunds),
    .tens       (tens),
    .units      (units),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] actual,
                       input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push_exp(input logic [6:0] u, input logic [6:0] t, input logic [6:0] h);
    frame_exp_t e;
    e.u = u;
    e.t = t;
    e.h = h;
    sb_q.push_back(e);
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle load strobe driven from a falling edge; ends one negedge later.
  task automatic pulse_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    load  = 1'b1;
    hunds = h;
    tens  = t;
    units = u;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Wait (bounded) for the frame_done sample at a falling edge.
  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 4 * FRAME_N);
    check("fd_seen", 16'(frame_done), 16'd1);
  endtask

  // Monitor: per-cycle seg/an checks against the popped frame, dwell length
  // per digit and frame_done spacing.
  initial begin : monitor
    logic [2:0] prev_an;
    int         run_len;
    int         fd_cnt;
    bit         in_frame;
    frame_exp_t cur;
    logic [6:0] exp_seg;
    prev_an  = '0;
    run_len  = 0;
    fd_cnt   = 0;
    in_frame = 0;
    cur      = '{u: 7'h00, t: 7'h00, h: 7'h00};
    forever begin
      @(negedge clk);
      if (!mon_stop) begin
        if (rst) begin
          prev_an  = '0;
          run_len  = 0;
          fd_cnt   = 0;
          in_frame = 0;
        end else begin
          fd_cnt++;
          if (an != prev_an) begin
            if (prev_an != 3'b000) check("dwell", 16'(run_len), 16'(DIV));
            run_len = 1;
            prev_an = an;
            if (an == 3'b001) begin
              check("sb_avail", 16'(sb_q.size() > 0), 16'd1);
              if (sb_q.size() > 0) begin
                cur      = sb_q.pop_front();
                in_frame = 1;
              end else begin
                in_frame = 0;
              end
            end
          end else begin
            run_len++;
          end
          check("an_onehot", 16'($countones(an)), 16'd1);
          if (in_frame && $countones(an) == 1) begin
            exp_seg = (an == 3'b001) ? cur.u : (an == 3'b010) ? cur.t : cur.h;
            check(an == 3'b001 ? "seg_units" : an == 3'b010 ? "seg_tens" : "seg_hunds",
                  16'(seg), 16'(exp_seg));
          end
          if (frame_done) begin
            check("fd_period", 16'(fd_cnt), 16'(FRAME_N));
            check("fd_an", 16'(an), 16'h4);
            fd_cnt = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    n_checks = 0;
    n_fail   = 0;
    mon_stop = 0;
    rst      = 1'b1;
    load     = 1'b0;
    hunds    = '0;
    tens     = '0;
    units    = '0;

    // Reset state.
    skip(2);
    check("rst_seg", 16'(seg), 16'h00);
    check("rst_an", 16'(an), 16'h0);
    check("rst_fd", 16'(frame_done), 16'd0);

    // F0: nothing loaded yet, all digits dark.
    push_exp(7'h00, 7'h00, 7'h00);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 check("first_an", 16'(an), 16'h1);

    // F1: still dark; 2/5/5 loaded mid-frame stays hidden.
    wait_fd();
    push_exp(7'h00, 7'h00, 7'h00);
    skip(6);
    pulse_load(4'd2, 4'd5, 4'd5);

    // F2: 255. Load 0/0/7 during it.
    wait_fd();
    push_exp(7'h6D, 7'h6D, 7'h5B);
    skip(3);
    pulse_load(4'd0, 4'd0, 4'd7);

    // F3: 7 with two blanked leading zeros. Load 0/0/0.
    wait_fd();
    push_exp(7'h07, 7'h00, 7'h00);
    skip(7);
    pulse_load(4'd0, 4'd0, 4'd0);

    // F4: 0 in units only. Load 128 then 099 in the same frame.
    wait_fd();
    push_exp(7'h3F, 7'h00, 7'h00);
    skip(2);
    pulse_load(4'd1, 4'd2, 4'd8);
    skip(5);
    pulse_load(4'd0, 4'd9, 4'd9);

    // F5: 99 (128 never shown). Load 345 exactly on the boundary cycle.
    wait_fd();
    push_exp(7'h6F, 7'h6F, 7'h00);
    skip(11);
    pulse_load(4'd3, 4'd4, 4'd5);
    check("boundary_align", 16'(frame_done), 16'd1);

    // F6: 345. Load hunds 0, tens 12, units 1.
    push_exp(7'h6D, 7'h66, 7'h4F);
    skip(5);
    pulse_load(4'd0, 4'd12, 4'd1);

    // F7 and F8: dash in tens is not blanked.
    wait_fd();
    push_exp(7'h06, 7'h40, 7'h00);
    wait_fd();
    push_exp(7'h06, 7'h40, 7'h00);
    skip(3);
    pulse_load(4'd9, 4'd8, 4'd7);
    skip(2);

    // Reset in the tens window clears outputs without a clock edge.
    #2 rst = 1'b1;
    #1;
    check("async_seg", 16'(seg), 16'h00);
    check("async_an", 16'(an), 16'h0);
    check("async_fd", 16'(frame_done), 16'd0);
    skip(2);
    check("hold_an", 16'(an), 16'h0);

    // F9, F10: pending 987 and old shadow are gone, display stays dark.
    push_exp(7'h00, 7'h00, 7'h00);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 check("restart_an", 16'(an), 16'h1);
    wait_fd();
    push_exp(7'h00, 7'h00, 7'h00);
    wait_fd();
    mon_stop = 1;

    check("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
